// File: rtl/step_count_ctrl.sv
// Button-driven step counter: synchronizes and debounces the press, adds STEP with wrap
// past LIMIT, and runs a shift-add-3 conversion that feeds latched BCD digits to the display.
module step_count_ctrl #(
  parameter int WIDTH           = 8,
  parameter int STEP            = 10,
  parameter int LIMIT           = 150,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select_button,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       bcd_centenas,
  output logic [3:0]       bcd_decenas,
  output logic [3:0]       bcd_unidades,
  output logic             bcd_valid,
  output logic             busy,
  output logic             count_reached,
  output logic [4:0]       led
);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW  = $clog2(WIDTH + 1);
  localparam int SW  = WIDTH + 12;
  localparam logic [WIDTH:0]   STEP_W  = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   LIMIT_W = (WIDTH + 1)'(LIMIT);
  localparam logic [DBW-1:0]   DEB_END = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    CONV_END = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, CONV, LOAD} state_t;
  state_t state, next_state;

  logic             sync1, sync2, deb_level, press;
  logic [DBW-1:0]   deb_cnt;
  logic             pending, next_pending;
  logic [CW-1:0]    conv_cnt;
  logic             conv_last;
  logic [SW-1:0]    shreg, shreg_next;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] add_count;
  logic [4:0]       add_led;

  // The press pulse fires only on the debounced 0->1 change, one cycle wide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      sync1 <= select_button;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_END) begin
        deb_cnt   <= '0;
        deb_level <= sync2;
        press     <= sync2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sum = {1'b0, count} + STEP_W;
    if (sum > LIMIT_W) begin
      add_count = '0;
      add_led   = '0;
    end else begin
      add_count = sum[WIDTH-1:0];
      add_led   = (led == 5'd31) ? led : led + 5'd1;
    end
  end

  always_comb begin
    shreg_next = shreg;
    for (int i = 0; i < 3; i++) begin
      if (shreg[WIDTH + 4*i +: 4] >= 4'd5)
        shreg_next[WIDTH + 4*i +: 4] = shreg[WIDTH + 4*i +: 4] + 4'd3;
    end
    shreg_next = shreg_next << 1;
  end

  assign conv_last = (conv_cnt == CONV_END);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state   <= next_state;
      pending <= next_pending;
    end
  end

  // A press arriving in any busy state, LOAD included, is parked in the one-deep pending slot.
  always_comb begin
    next_state   = state;
    next_pending = pending;
    case (state)
      IDLE: if (press || pending) begin
        next_state   = ADD;
        next_pending = 1'b0;
      end
      ADD:  next_state = CONV;
      CONV: if (conv_last) next_state = LOAD;
      LOAD: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (press && (state != IDLE) && !pending)
      next_pending = 1'b1;
  end

  // Digits latch on the final shift so they and bcd_valid are both visible during LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count         <= '0;
      led           <= '0;
      count_reached <= 1'b0;
      shreg         <= '0;
      conv_cnt      <= '0;
      bcd_centenas  <= '0;
      bcd_decenas   <= '0;
      bcd_unidades  <= '0;
      bcd_valid     <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        ADD: begin
          count         <= add_count;
          led           <= add_led;
          count_reached <= (add_count == LIMIT_W[WIDTH-1:0]);
          shreg         <= {12'd0, add_count};
          conv_cnt      <= '0;
        end
        CONV: begin
          shreg    <= shreg_next;
          conv_cnt <= conv_cnt + 1'b1;
          if (conv_last) begin
            bcd_centenas <= shreg_next[SW-1 -: 4];
            bcd_decenas  <= shreg_next[SW-5 -: 4];
            bcd_unidades <= shreg_next[SW-9 -: 4];
            bcd_valid    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_step_count_ctrl.sv
// Self-checking bench for step_count_ctrl: a scoreboard of predicted counts/digits is popped
// on every bcd_valid; scenario tasks check timing, glitches, wrap, pending and reset.
module tb_step_count_ctrl;
  localparam int WIDTH = 8;
  localparam int WIDTH_W = 16;
  localparam int STEP = 10;
  localparam int LIMIT = 150;
  localparam int DEB = 4;
  localparam int LAT = 2 + DEB + WIDTH + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic button = 1'b0;
  logic button_w = 1'b0;

  logic [WIDTH-1:0] count;
  logic [3:0] bcd_centenas, bcd_decenas, bcd_unidades;
  logic bcd_valid, busy, count_reached;
  logic [4:0] led;

  logic [WIDTH_W-1:0] count_w;
  logic [3:0] cen_w, dec_w, uni_w;
  logic valid_w, busy_w, reached_w;
  logic [4:0] led_w;

  typedef struct packed {
    logic [7:0] count;
    logic [3:0] cen;
    logic [3:0] dec;
    logic [3:0] uni;
    logic [4:0] led;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp, mon_got;
  int passed = 0;
  int total = 0;
  int valid_seen = 0;
  int valid_w_seen = 0;
  int m_count = 0;
  int m_led = 0;

  step_count_ctrl #(.WIDTH(WIDTH), .STEP(STEP), .LIMIT(LIMIT), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .select_button(button), .count(count),
    .bcd_centenas(bcd_centenas), .bcd_decenas(bcd_decenas), .bcd_unidades(bcd_unidades),
    .bcd_valid(bcd_valid), .busy(busy), .count_reached(count_reached), .led(led));

  // Wide conversion keeps the FSM busy long enough for a third edge to land while pending.
  step_count_ctrl #(.WIDTH(WIDTH_W), .STEP(STEP), .LIMIT(LIMIT), .DEBOUNCE_CYCLES(DEB)) dut_w (
    .clk(clk), .reset(reset), .select_button(button_w), .count(count_w),
    .bcd_centenas(cen_w), .bcd_decenas(dec_w), .bcd_unidades(uni_w),
    .bcd_valid(valid_w), .busy(busy_w), .count_reached(reached_w), .led(led_w));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bcd_valid === 1'b1) begin
      valid_seen++;
      total++;
      mon_got = {count, bcd_centenas, bcd_decenas, bcd_unidades, led};
      if (sb.size() == 0) begin
        $display("[TB] FAIL unexpected_bcd_valid: got %h with no expected entry", mon_got);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp)
          $display("[TB] FAIL scoreboard: got %h required %h", mon_got, mon_exp);
        else
          passed++;
      end
    end
    if (valid_w === 1'b1) valid_w_seen++;
  end

  task automatic model_press();
    exp_t e;
    if (m_count + STEP > LIMIT) begin
      m_count = 0;
      m_led = 0;
    end else begin
      m_count += STEP;
      if (m_led < 31) m_led++;
    end
    e.count = 8'(m_count);
    e.cen = 4'(m_count / 100);
    e.dec = 4'((m_count / 10) % 10);
    e.uni = 4'(m_count % 10);
    e.led = 5'(m_led);
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_count = 0;
    m_led = 0;
  endtask

  task automatic press_button(input int hold, input int rel);
    button = 1'b1;
    repeat (hold) @(negedge clk);
    button = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (count !== 8'd0) $display("[TB] FAIL reset_count: got %0d required 0", count);
    else passed++;
    total++;
    if ({bcd_centenas, bcd_decenas, bcd_unidades} !== 12'h000)
      $display("[TB] FAIL reset_digits: got %h required 000", {bcd_centenas, bcd_decenas, bcd_unidades});
    else passed++;
    total++;
    if ({count_reached, busy, bcd_valid, led} !== 8'd0)
      $display("[TB] FAIL reset_flags: got %b required 0", {count_reached, busy, bcd_valid, led});
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_press();
    int lat = -1;
    logic [WIDTH-1:0] c7 = '1, c8 = '1;
    model_press();
    button = 1'b1;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 10) button = 1'b0;
      if (i == 7) c7 = count;
      if (i == 8) c8 = count;
      if (bcd_valid === 1'b1) lat = i;
    end
    button = 1'b0;
    total++;
    if (lat != LAT) $display("[TB] FAIL valid_latency: got %0d required %0d", lat, LAT);
    else passed++;
    total++;
    if (c7 !== 8'd0 || c8 !== 8'd10)
      $display("[TB] FAIL add_timing: got %0d,%0d required 0,10", c7, c8);
    else passed++;
    repeat (10) @(negedge clk);
    total++;
    if ({count, led, bcd_centenas, bcd_decenas, bcd_unidades, busy} !== {8'd10, 5'd1, 12'h010, 1'b0})
      $display("[TB] FAIL single_press: got count=%0d led=%0d digits=%h busy=%b required 10 1 010 0",
               count, led, {bcd_centenas, bcd_decenas, bcd_unidades}, busy);
    else passed++;
  endtask

  task automatic test_glitch();
    int v0;
    apply_reset();
    v0 = valid_seen;
    press_button(2, 20);
    total++;
    if (count !== 8'd0 || valid_seen != v0)
      $display("[TB] FAIL glitch: got count=%0d pulses=%0d required 0 0", count, valid_seen - v0);
    else passed++;
  endtask

  task automatic test_count_to_limit();
    int v0 = valid_seen;
    for (int i = 0; i < 15; i++) begin
      model_press();
      press_button(10, 10);
    end
    repeat (5) @(negedge clk);
    total++;
    if (count !== 8'd150 || count_reached !== 1'b1 || led !== 5'd15)
      $display("[TB] FAIL limit_state: got count=%0d reached=%b led=%0d required 150 1 15",
               count, count_reached, led);
    else passed++;
    total++;
    if ({bcd_centenas, bcd_decenas, bcd_unidades} !== 12'h150)
      $display("[TB] FAIL limit_digits: got %h required 150", {bcd_centenas, bcd_decenas, bcd_unidades});
    else passed++;
    total++;
    if (valid_seen - v0 != 15 || sb.size() != 0)
      $display("[TB] FAIL limit_pulses: got %0d left %0d required 15 0", valid_seen - v0, sb.size());
    else passed++;
  endtask

  task automatic test_wrap();
    model_press();
    press_button(10, 10);
    repeat (5) @(negedge clk);
    total++;
    if ({count, count_reached, led, bcd_centenas, bcd_decenas, bcd_unidades} !== 26'd0)
      $display("[TB] FAIL wrap: got count=%0d reached=%b led=%0d digits=%h required all 0",
               count, count_reached, led, {bcd_centenas, bcd_decenas, bcd_unidades});
    else passed++;
  endtask

  task automatic test_back_to_back();
    int v0, vw0;
    apply_reset();
    v0 = valid_seen;
    model_press();
    model_press();
    press_button(4, 5);
    press_button(10, 15);
    repeat (10) @(negedge clk);
    total++;
    if (count !== 8'd20 || led !== 5'd2 || valid_seen - v0 != 2)
      $display("[TB] FAIL pending: got count=%0d led=%0d pulses=%0d required 20 2 2",
               count, led, valid_seen - v0);
    else passed++;
    vw0 = valid_w_seen;
    for (int k = 0; k < 2; k++) begin
      button_w = 1'b1;
      repeat (4) @(negedge clk);
      button_w = 1'b0;
      repeat (4) @(negedge clk);
    end
    button_w = 1'b1;
    repeat (10) @(negedge clk);
    button_w = 1'b0;
    repeat (50) @(negedge clk);
    total++;
    if (count_w !== 16'd20 || led_w !== 5'd2 || valid_w_seen - vw0 != 2)
      $display("[TB] FAIL pending_drop: got count=%0d led=%0d pulses=%0d required 20 2 2",
               count_w, led_w, valid_w_seen - vw0);
    else passed++;
  endtask

  task automatic test_reset_during_conv();
    int v0;
    bit seen = 0;
    apply_reset();
    v0 = valid_seen;
    button = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (busy === 1'b1) seen = 1;
    end
    total++;
    if (!seen) $display("[TB] FAIL busy_timeout: got busy=%b required 1", busy);
    else passed++;
    repeat (3) @(negedge clk);
    button = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if ({count, bcd_centenas, bcd_decenas, bcd_unidades, bcd_valid, busy, count_reached, led} !== 28'd0)
      $display("[TB] FAIL reset_conv: got count=%0d busy=%b led=%0d required 0 0 0", count, busy, led);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    total++;
    if (valid_seen != v0 || count !== 8'd0)
      $display("[TB] FAIL reset_conv_after: got pulses=%0d count=%0d required 0 0", valid_seen - v0, count);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_count_to_limit();
    test_wrap();
    test_back_to_back();
    test_reset_during_conv();
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
